// File: rtl/spi_gray_tx.sv
// ---------------------------------------------------------------------------
// spi_gray_tx
// SPI mode-0 (CPOL=0, CPHA=0) transmit stage that sits after the Gray coder.
// It accepts one LEN-bit word per valid/ready handshake and shifts it out MSB
// first as a single chip-select framed transfer. Words that are all ones (the
// coder's error code) are sent like any other word and also raise o_err.
//
// Parameters
//   LEN      word width in bits (>= 2), must match the Gray coder
//   CLK_DIV  i_clk cycles per SCLK half-period (>= 1)
//
// Ports
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_valid  i_gray holds a word to send
//   o_ready  a word can be accepted this cycle (IDLE only)
//   i_gray   Gray word, sampled only at accept
//   o_cs_n   SPI chip select, active low
//   o_sclk   SPI clock, idles low
//   o_mosi   SPI serial data, MSB first
//   o_busy   frame in progress (state != IDLE)
//   o_err    last accepted word was all ones; held until the next accept
//   o_done   one-cycle pulse in the IDLE cycle that ends a frame
//
// Every output is a register whose next value is decoded from the next state,
// so each output lines up with the state it belongs to and never glitches.
// ---------------------------------------------------------------------------
module spi_gray_tx #(
   parameter int unsigned LEN     = 4,
   parameter int unsigned CLK_DIV = 2
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic [LEN-1:0] i_gray,
   output logic           o_cs_n,
   output logic           o_sclk,
   output logic           o_mosi,
   output logic           o_busy,
   output logic           o_err,
   output logic           o_done
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(LEN);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   // Control / datapath state
   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic [CNT_W-1:0] bit_q,   bit_d;
   logic [LEN-1:0]   sh_q,    sh_d;
   logic             sclk_q,  sclk_d;
   logic             err_q,   err_d;

   // Registered output copies
   logic             cs_n_q,  cs_n_d;
   logic             mosi_q,  mosi_d;
   logic             ready_q, ready_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   // End of the current SCLK half-period (or SETUP/HOLD phase)
   logic             tick;

   assign tick = (div_q == DIV_LAST);

   // State register: all flops, cleared to the idle picture on reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         sclk_q  <= 1'b0;
         err_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         sclk_q  <= sclk_d;
         err_q   <= err_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      sclk_d  = sclk_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE: begin
            sclk_d = 1'b0;
            if (i_valid) begin
               state_d = ST_SETUP;
               sh_d    = i_gray;
               err_d   = &i_gray;
               bit_d   = '0;
            end
         end

         ST_SETUP: begin
            sclk_d = 1'b0;
            if (tick) begin
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               // Falling half: present the next bit, or finish after LEN bits
               if (sclk_q) begin
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_HOLD;
                     sclk_d  = 1'b0;
                     bit_d   = '0;
                  end else begin
                     sh_d  = {sh_q[LEN-2:0], 1'b0};
                     bit_d = bit_q + CNT_W'(1);
                  end
               end
            end
         end

         ST_HOLD: begin
            sclk_d = 1'b0;
            if (tick) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            sclk_d  = 1'b0;
         end
      endcase

      // Divider restarts on every state change and wraps on each tick
      if ((state_q == ST_IDLE) || (state_d != state_q) || tick) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Output decode from the next state so outputs align with their state
   always_comb begin
      cs_n_d  = 1'b1;
      mosi_d  = 1'b0;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;

      unique case (state_d)
         ST_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = (state_q == ST_HOLD);
         end
         ST_SETUP, ST_SHIFT: begin
            cs_n_d = 1'b0;
            mosi_d = sh_d[LEN-1];
         end
         ST_HOLD: begin
            cs_n_d = 1'b0;
         end
         default: begin
            cs_n_d = 1'b1;
         end
      endcase
   end

   assign o_ready = ready_q;
   assign o_cs_n  = cs_n_q;
   assign o_sclk  = sclk_q;
   assign o_mosi  = mosi_q;
   assign o_busy  = busy_q;
   assign o_err   = err_q;
   assign o_done  = done_q;

endmodule
